// File: rtl/i2s_clk_ctrl.sv
// I2S clock controller: generates SCLK/LRCLK from the system clock with a
// frame-aligned start/stop FSM. It also forwards FIFO samples to the transmitter
// and substitutes a mute frame on underrun.
module i2s_clk_ctrl #(
  parameter int unsigned DW       = 24,
  parameter int unsigned SLOT     = 32,
  parameter int unsigned SCLK_DIV = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  output logic          sclk,
  output logic          lrclk,
  input  logic          tx_rd_en,
  output logic          tx_rd_valid,
  output logic [DW-1:0] tx_l,
  output logic [DW-1:0] tx_r,
  input  logic          fifo_empty,
  output logic          fifo_rd_en,
  input  logic          fifo_rd_valid,
  input  logic [DW-1:0] fifo_l,
  input  logic [DW-1:0] fifo_r,
  output logic          running,
  output logic          underrun,
  output logic [15:0]   underrun_cnt,
  input  logic          clr
);

  localparam int unsigned DivW = (SCLK_DIV > 2) ? $clog2(SCLK_DIV) : 1;
  localparam int unsigned BitW = $clog2(2 * SLOT);

  localparam logic [DivW-1:0] DivMax  = DivW'(SCLK_DIV - 1);
  localparam logic [DivW-1:0] DivHalf = DivW'(SCLK_DIV / 2);
  localparam logic [BitW-1:0] BitMax  = BitW'(2 * SLOT - 1);
  localparam logic [BitW-1:0] SlotB   = BitW'(SLOT);

  typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

  state_e          state_q, state_d;
  logic [DivW-1:0] div_q, div_d;
  logic [BitW-1:0] bit_q, bit_d;
  logic            sclk_q, sclk_d;
  logic            lrclk_q, lrclk_d;
  logic            running_q, running_d;
  logic            mute_q, mute_d;
  logic            tx_valid_q, tx_valid_d;
  logic [DW-1:0]   tx_l_q, tx_l_d;
  logic [DW-1:0]   tx_r_q, tx_r_d;
  logic            underrun_q, underrun_d;
  logic [15:0]     ur_cnt_q, ur_cnt_d;

  logic div_wrap;
  logic frame_wrap;
  logic ur_event;

  // Next-state for the clock FSM, divider and bit counter
  always_comb begin
    state_d    = state_q;
    div_d      = div_q;
    bit_d      = bit_q;
    sclk_d     = sclk_q;
    lrclk_d    = lrclk_q;
    div_wrap   = (div_q == DivMax);
    frame_wrap = div_wrap && (bit_q == BitMax);

    unique case (state_q)
      StIdle:  if (en) state_d = StRun;
      StRun:   if (!en) state_d = StDrain;
      StDrain: begin
        if (en) begin
          state_d = StRun;
        end else if (frame_wrap) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // Counting only continues while we stay active; entering RUN from IDLE
    // starts from the idle values so the first RUN cycle has sclk=0.
    if ((state_q != StIdle) && (state_d != StIdle)) begin
      div_d  = div_wrap ? '0 : div_q + DivW'(1);
      sclk_d = (div_d >= DivHalf);
      if (div_wrap) begin
        bit_d   = (bit_q == BitMax) ? '0 : bit_q + BitW'(1);
        // LRCLK takes the slot of the bit just finished, so it leads the
        // data by one SCLK as I2S requires.
        lrclk_d = (bit_q >= SlotB);
      end
    end else begin
      div_d   = '0;
      bit_d   = '0;
      sclk_d  = 1'b0;
      lrclk_d = 1'b1;
    end

    running_d = (state_d != StIdle);
  end

  assign fifo_rd_en = tx_rd_en & ~fifo_empty & running_q & ~rst;
  assign ur_event   = tx_rd_en & fifo_empty & running_q;

  // Next-state for the sample path and underrun bookkeeping
  always_comb begin
    mute_d     = ur_event;
    tx_valid_d = fifo_rd_valid | mute_q;
    tx_l_d     = mute_q ? '0 : fifo_l;
    tx_r_d     = mute_q ? '0 : fifo_r;
    underrun_d = underrun_q;
    ur_cnt_d   = ur_cnt_q;
    if (clr) begin
      // A coincident event survives the clear as the first event counted.
      underrun_d = ur_event;
      ur_cnt_d   = ur_event ? 16'd1 : 16'd0;
    end else if (ur_event) begin
      underrun_d = 1'b1;
      if (ur_cnt_q != 16'hFFFF) ur_cnt_d = ur_cnt_q + 16'd1;
    end
  end

  // All state registers; reset wins over every input
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      div_q      <= '0;
      bit_q      <= '0;
      sclk_q     <= 1'b0;
      lrclk_q    <= 1'b1;
      running_q  <= 1'b0;
      mute_q     <= 1'b0;
      tx_valid_q <= 1'b0;
      tx_l_q     <= '0;
      tx_r_q     <= '0;
      underrun_q <= 1'b0;
      ur_cnt_q   <= '0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      bit_q      <= bit_d;
      sclk_q     <= sclk_d;
      lrclk_q    <= lrclk_d;
      running_q  <= running_d;
      mute_q     <= mute_d;
      tx_valid_q <= tx_valid_d;
      tx_l_q     <= tx_l_d;
      tx_r_q     <= tx_r_d;
      underrun_q <= underrun_d;
      ur_cnt_q   <= ur_cnt_d;
    end
  end

  assign sclk         = sclk_q;
  assign lrclk        = lrclk_q;
  assign running      = running_q;
  assign tx_rd_valid  = tx_valid_q;
  assign tx_l         = tx_l_q;
  assign tx_r         = tx_r_q;
  assign underrun     = underrun_q;
  assign underrun_cnt = ur_cnt_q;

endmodule

// File: tb/tb_i2s_clk_ctrl.sv
// Self-checking bench for i2s_clk_ctrl: random traffic plus directed drain,
// saturation and reset scenarios, compared every cycle against a timeline model.
module tb_i2s_clk_ctrl;

  localparam int DW    = 24;
  localparam int SLOT  = 32;
  localparam int DIV   = 4;
  localparam int FRAME = 2 * SLOT * DIV;

  logic          clk = 1'b0;
  logic          rst, en, tx_rd_en, fifo_empty, fifo_rd_valid, clr;
  logic [DW-1:0] fifo_l, fifo_r;
  logic          sclk, lrclk, tx_rd_valid, fifo_rd_en, running, underrun;
  logic [DW-1:0] tx_l, tx_r;
  logic [15:0]   underrun_cnt;

  int errors = 0;
  int checks = 0;

  // Model: state (0 idle, 1 run, 2 drain) and t = clk cycles since RUN began.
  int            m_st = 0;
  int            t = 0;
  bit            m_ev_prev = 0;
  bit            e_valid = 0;
  logic [DW-1:0] e_l = '0, e_r = '0;
  bit            e_ur = 0;
  int            e_cnt = 0;
  bit            fire = 0;
  bit            stray = 0;

  i2s_clk_ctrl #(.DW(DW), .SLOT(SLOT), .SCLK_DIV(DIV)) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .sclk         (sclk),
    .lrclk        (lrclk),
    .tx_rd_en     (tx_rd_en),
    .tx_rd_valid  (tx_rd_valid),
    .tx_l         (tx_l),
    .tx_r         (tx_r),
    .fifo_empty   (fifo_empty),
    .fifo_rd_en   (fifo_rd_en),
    .fifo_rd_valid(fifo_rd_valid),
    .fifo_l       (fifo_l),
    .fifo_r       (fifo_r),
    .running      (running),
    .underrun     (underrun),
    .underrun_cnt (underrun_cnt),
    .clr          (clr)
  );

  always #5 clk = ~clk;

  function automatic bit exp_sclk();
    return (m_st != 0) && ((t % DIV) >= DIV / 2);
  endfunction

  // LRCLK is high in idle and until the first SCLK fall, then toggles every
  // half frame measured from that first fall.
  function automatic bit exp_lrclk();
    if (m_st == 0 || t < DIV) return 1'b1;
    return ((t - DIV) % FRAME) >= SLOT * DIV;
  endfunction

  function automatic int bit_idx();
    return (t / DIV) % (2 * SLOT);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Advance the model across one rising edge using this cycle's inputs.
  task automatic model_step();
    bit ev;
    ev = tx_rd_en && fifo_empty && (m_st != 0) && !rst;
    if (rst) begin
      m_st = 0; t = 0; m_ev_prev = 0;
      e_valid = 0; e_l = '0; e_r = '0; e_ur = 0; e_cnt = 0;
    end else begin
      e_valid   = m_ev_prev || fifo_rd_valid;
      e_l       = m_ev_prev ? '0 : fifo_l;
      e_r       = m_ev_prev ? '0 : fifo_r;
      m_ev_prev = ev;
      if (clr) begin
        e_ur  = ev;
        e_cnt = ev ? 1 : 0;
      end else if (ev) begin
        e_ur = 1;
        if (e_cnt < 65535) e_cnt++;
      end
      case (m_st)
        0: if (en) begin m_st = 1; t = 0; end
        1: begin t++; if (!en) m_st = 2; end
        default: begin
          if (en) begin
            m_st = 1; t++;
          end else if ((t + 1) % FRAME == 0) begin
            m_st = 0; t = 0;
          end else begin
            t++;
          end
        end
      endcase
    end
  endtask

  // One clock cycle: check at the falling edge, act as FIFO, step the model.
  task automatic tick();
    @(negedge clk);
    chk("running", 32'(running), 32'(m_st != 0));
    chk("sclk", 32'(sclk), 32'(exp_sclk()));
    chk("lrclk", 32'(lrclk), 32'(exp_lrclk()));
    chk("tx_rd_valid", 32'(tx_rd_valid), 32'(e_valid));
    chk("tx_l", 32'(tx_l), 32'(e_l));
    chk("tx_r", 32'(tx_r), 32'(e_r));
    chk("underrun", 32'(underrun), 32'(e_ur));
    chk("underrun_cnt", 32'(underrun_cnt), e_cnt);
    chk("fifo_rd_en", 32'(fifo_rd_en),
        32'(tx_rd_en && !fifo_empty && (m_st != 0) && !rst));
    fire = fifo_rd_en;
    @(posedge clk);
    model_step();
    #1;
    fifo_rd_valid = fire | stray;
    fifo_l = DW'($urandom);
    fifo_r = DW'($urandom);
  endtask

  task automatic run_to_bit(input int b);
    for (int i = 0; i < 2 * FRAME && !(m_st != 0 && bit_idx() == b && t % DIV == 0); i++) tick();
    chk("reach_bit", 32'(bit_idx()), b);
  endtask

  initial begin
    rst = 1; en = 1; tx_rd_en = 0; fifo_empty = 0; clr = 0;
    fifo_rd_valid = 0; fifo_l = '0; fifo_r = '0;

    // Reset with traffic present: reads must stay blocked.
    for (int i = 0; i < 3; i++) begin
      tx_rd_en = 1'($urandom);
      tick();
    end
    rst = 0; tx_rd_en = 0;

    // Free-running random traffic.
    for (int i = 0; i < 600; i++) begin
      tx_rd_en   = ($urandom % 6) == 0;
      fifo_empty = ($urandom % 4) == 0;
      clr        = ($urandom % 40) == 0;
      tick();
    end
    clr = 0; tx_rd_en = 0;

    // Single normal read, then single underrun.
    fifo_empty = 0; tick();
    tx_rd_en = 1; tick();
    tx_rd_en = 0; repeat (3) tick();
    fifo_empty = 1; tx_rd_en = 1; tick();
    tx_rd_en = 0; repeat (3) tick();

    // Drop en mid-frame: clocks must finish the frame, then idle.
    fifo_empty = 0;
    run_to_bit(10);
    en = 0;
    for (int i = 0; i < 2 * FRAME && m_st != 0; i++) begin
      tx_rd_en = ($urandom % 5) == 0;
      tick();
    end
    tick();
    chk("drained_idle", 32'(running), 0);

    // Idle: requests ignored, stray FIFO valid still forwarded.
    tx_rd_en = 1; fifo_empty = 1; tick();
    stray = 1; tick();
    stray = 0; tx_rd_en = 0; repeat (3) tick();

    // Re-raise en while draining: no gap in the clocks.
    en = 1; fifo_empty = 0;
    run_to_bit(20);
    en = 0; repeat (40) tick();
    en = 1;
    for (int i = 0; i < 300; i++) begin
      tx_rd_en = ($urandom % 7) == 0;
      tick();
    end

    // Saturate the counter, then clear together with an event.
    fifo_empty = 1; tx_rd_en = 1;
    repeat (65540) tick();
    clr = 1; tick();
    clr = 0; tx_rd_en = 0; tick();
    chk("clr_with_event", 32'(underrun_cnt), 1);
    clr = 1; tick();
    clr = 0; repeat (3) tick();

    // Reset at bit 40 with a read and an underrun in flight.
    fifo_empty = 0;
    run_to_bit(40);
    tx_rd_en = 1; tick();
    tx_rd_en = 0; rst = 1; tick();
    rst = 0; repeat (3) tick();
    run_to_bit(40);
    fifo_empty = 1; tx_rd_en = 1; tick();
    tx_rd_en = 0; rst = 1; tick();
    rst = 0; repeat (3) tick();

    // Random traffic with en toggling.
    for (int i = 0; i < 1500; i++) begin
      if (($urandom % 150) == 0) en = ~en;
      tx_rd_en   = ($urandom % 5) == 0;
      fifo_empty = ($urandom % 3) == 0;
      clr        = ($urandom % 60) == 0;
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/i2s_clk_ctrl.md
I2S_CLK_CTRL -- requirements
Module: i2s_clk_ctrl

Interface
REQ-001 Parameter DW, default 24: sample width in bits per channel.
REQ-002 Parameter SLOT, default 32: SCLK periods per channel slot; SHALL be at least DW.
REQ-003 Parameter SCLK_DIV, default 4: clk cycles per SCLK period; SHALL be even and at least 2.
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 en  in  1  level; 1 = run the I2S clocks, 0 = stop at the next frame boundary.
REQ-007 sclk  out  1  I2S bit clock, registered.
REQ-008 lrclk  out  1  I2S word clock, registered; 0 = left, 1 = right.
REQ-009 tx_rd_en  in  1  sample request pulse from the transmitter.
REQ-010 tx_rd_valid  out  1  sample-valid pulse to the transmitter.
REQ-011 tx_l, tx_r  out  DW each  samples to the transmitter.
REQ-012 fifo_empty  in  1  async-FIFO read-side empty flag.
REQ-013 fifo_rd_en  out  1  FIFO read strobe.
REQ-014 fifo_rd_valid  in  1  FIFO data valid; asserted exactly 1 cycle after fifo_rd_en.
REQ-015 fifo_l, fifo_r  in  DW each  FIFO sample outputs.
REQ-016 running  out  1  1 while in RUN or DRAIN.
REQ-017 underrun  out  1  sticky underrun flag.
REQ-018 underrun_cnt  out  16  saturating underrun event counter.
REQ-019 clr  in  1  pulse; clears underrun and underrun_cnt.

Function
REQ-020 FSM states SHALL be IDLE, RUN and DRAIN.
REQ-021 IDLE -> RUN when en=1; RUN -> DRAIN when en=0; DRAIN -> RUN when en=1.
REQ-022 DRAIN -> IDLE on the cycle the frame wraps (bit_cnt 2*SLOT-1 -> 0).
REQ-023 In IDLE: sclk=0, lrclk=1, div_cnt=0, bit_cnt=0.
REQ-024 div_cnt counts 0..SCLK_DIV-1 and wraps while RUN or DRAIN.
REQ-025 sclk SHALL be 0 for div_cnt < SCLK_DIV/2 and 1 otherwise; the first RUN cycle has sclk=0.
REQ-026 bit_cnt (0..2*SLOT-1) SHALL advance on the falling edge of sclk (div_cnt wrap) and wrap to 0.
REQ-027 lrclk SHALL update only on sclk falling edges: 0 for bit_cnt < SLOT, 1 otherwise.
REQ-028 Consequence of REQ-023/027: lrclk goes 1 -> 0 on the first sclk falling edge after entering RUN.
REQ-029 fifo_rd_en SHALL equal tx_rd_en AND NOT fifo_empty AND running, combinationally.
REQ-030 tx_rd_en in IDLE SHALL be ignored: no read, no underrun event.
REQ-031 Normal path: tx_rd_valid, tx_l and tx_r SHALL be registered copies of fifo_rd_valid, fifo_l and fifo_r.
REQ-032 This gives total latency tx_rd_en -> tx_rd_valid = 2 cycles.
REQ-033 Underrun: tx_rd_en=1 with fifo_empty=1 while running is an underrun event.
REQ-034 On an underrun event, 2 cycles later: tx_rd_valid=1, tx_l=0, tx_r=0 (mute frame).
REQ-035 On an underrun event: underrun set to 1 and underrun_cnt incremented, saturating at 0xFFFF.
REQ-036 clr alone SHALL zero underrun and underrun_cnt next cycle.
REQ-037 clr together with an underrun event SHALL leave underrun=1 and underrun_cnt=1.
REQ-038 A stray fifo_rd_valid in IDLE SHALL still be forwarded per REQ-031.
REQ-039 en toggling inside a frame SHALL never truncate a frame; only a frame wrap in DRAIN stops the clocks.

Reset
REQ-040 rst has priority over all inputs, including clr and en.
REQ-041 rst mid-frame SHALL force IDLE, sclk=0, lrclk=1, div_cnt=0 and bit_cnt=0 on the next cycle.
REQ-042 rst SHALL force fifo_rd_en=0 combinationally.
REQ-043 rst SHALL clear tx_rd_valid, tx_l, tx_r, running, underrun and underrun_cnt, and drop in-flight mute requests.

Verification (DW=24, SLOT=32, SCLK_DIV=4: 4 clk per SCLK, 256 clk per frame)
REQ-044 rst, en=1 at cycle 0 -> running=1 at cycle 1; sclk pattern 0,0,1,1; lrclk falls at cycle 5; lrclk rises 128 clk later; period 256 clk.
REQ-045 fifo_empty=0, tx_rd_en pulse with fifo_l=0xABCDEF -> same-cycle fifo_rd_en; tx_rd_valid=1 and tx_l=0xABCDEF 2 cycles after tx_rd_en.
REQ-046 fifo_empty=1, tx_rd_en pulse -> fifo_rd_en=0; tx_rd_valid=1 with tx_l=tx_r=0 after 2 cycles; underrun=1; underrun_cnt=1.
REQ-047 en dropped at bit_cnt=10 -> clocks continue to the frame wrap, then IDLE with sclk=0, lrclk=1, running=0; en re-raised in DRAIN -> no gap in the clocks.
REQ-048 Preload underrun_cnt to 0xFFFF, then an underrun -> stays 0xFFFF; clr plus an underrun in the same cycle -> underrun_cnt=1.
REQ-049 rst asserted at bit_cnt=40 -> next cycle IDLE, all outputs at reset values, no tx_rd_valid emitted for the dropped request.
